// File: rtl/adapter_32_8.sv
// 32-bit to 8-bit AXI4-Lite width down-converter.
// Each 32-bit access becomes a series of single-byte accesses on the master side.
// Read and write paths are independent, each with one transaction in flight.
module adapter_32_8 #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // 32-bit slave side
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  // 8-bit master side
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [7:0]            m_axi_wdata,
  output logic                  m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [7:0]            m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [1:0] {WIdle, WAddr, WResp, WBresp} w_state_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData, RResp} r_state_e;

  // Response codes are ordered by severity, so the merge is a numeric max.
  function automatic logic [1:0] max_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    if (m[2]) return 2'd2;
    return 2'd3;
  endfunction

  w_state_e              w_state;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-3:0] aw_base;
  logic [2:0]            aw_prot;
  logic [31:0]           w_data;
  logic [3:0]            w_pend;     // lanes still to be issued
  logic [1:0]            w_resp;
  logic [1:0]            w_lane;
  logic [3:0]            w_pend_next;
  logic [1:0]            w_merged;

  r_state_e              r_state;
  logic [ADDR_WIDTH-3:0] r_base;
  logic [1:0]            r_lane;
  logic [31:0]           r_buf;
  logic [31:0]           r_buf_next;
  logic [1:0]            r_resp;
  logic [1:0]            r_merged;

  // Byte-address low bits are replaced by the lane index.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign m_axi_wstrb = 1'b1;

  // Next lane to issue and the merged responses.
  always_comb begin
    w_lane      = low_lane(w_pend);
    w_pend_next = w_pend & ~(4'b0001 << w_lane);
    w_merged    = max_resp(w_resp, m_axi_bresp);
    r_merged    = max_resp(r_resp, m_axi_rresp);
    r_buf_next  = r_buf;
    r_buf_next[{r_lane, 3'b000} +: 8] = m_axi_rdata;
  end

  // Write path FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state       <= WIdle;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_base       <= '0;
      aw_prot       <= 3'b000;
      w_data        <= 32'h0;
      w_pend        <= 4'h0;
      w_resp        <= 2'b00;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      m_axi_awaddr  <= '0;
      m_axi_awprot  <= 3'b000;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= 8'h00;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      unique case (w_state)
        WIdle: begin
          if (s_axi_awvalid && s_axi_awready) begin
            aw_held <= 1'b1;
            aw_base <= s_axi_awaddr[ADDR_WIDTH-1:2];
            aw_prot <= s_axi_awprot;
          end
          if (s_axi_wvalid && s_axi_wready) begin
            w_held <= 1'b1;
            w_data <= s_axi_wdata;
            w_pend <= s_axi_wstrb;
          end
          s_axi_awready <= !aw_held && !(s_axi_awvalid && s_axi_awready);
          s_axi_wready  <= !w_held && !(s_axi_wvalid && s_axi_wready);
          if (aw_held && w_held) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            if (w_pend == 4'h0) begin
              s_axi_bresp  <= 2'b00;
              s_axi_bvalid <= 1'b1;
              w_state      <= WBresp;
            end else begin
              m_axi_awaddr  <= {aw_base, w_lane};
              m_axi_awprot  <= aw_prot;
              m_axi_wdata   <= w_data[{w_lane, 3'b000} +: 8];
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              w_pend        <= w_pend_next;
              w_state       <= WAddr;
            end
          end
        end
        WAddr: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            w_state      <= WResp;
          end
        end
        WResp: begin
          if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bready <= 1'b0;
            w_resp       <= w_merged;
            if (w_pend != 4'h0) begin
              m_axi_awaddr  <= {aw_base, w_lane};
              m_axi_wdata   <= w_data[{w_lane, 3'b000} +: 8];
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              w_pend        <= w_pend_next;
              w_state       <= WAddr;
            end else begin
              s_axi_bresp  <= w_merged;
              s_axi_bvalid <= 1'b1;
              w_state      <= WBresp;
            end
          end
        end
        WBresp: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            w_resp        <= 2'b00;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            w_state       <= WIdle;
          end
        end
        default: w_state <= WIdle;
      endcase
    end
  end

  // Read path FSM: always four byte reads, lanes 0..3, assembled little-endian.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= RIdle;
      r_base        <= '0;
      r_lane        <= 2'd0;
      r_buf         <= 32'h0;
      r_resp        <= 2'b00;
      s_axi_arready <= 1'b0;
      s_axi_rdata   <= 32'h0;
      s_axi_rresp   <= 2'b00;
      s_axi_rvalid  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arprot  <= 3'b000;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      unique case (r_state)
        RIdle: begin
          s_axi_arready <= !(s_axi_arvalid && s_axi_arready);
          if (s_axi_arvalid && s_axi_arready) begin
            r_base        <= s_axi_araddr[ADDR_WIDTH-1:2];
            r_lane        <= 2'd0;
            m_axi_araddr  <= {s_axi_araddr[ADDR_WIDTH-1:2], 2'b00};
            m_axi_arprot  <= s_axi_arprot;
            m_axi_arvalid <= 1'b1;
            r_state       <= RAddr;
          end
        end
        RAddr: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            r_state       <= RData;
          end
        end
        RData: begin
          if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rready <= 1'b0;
            r_buf        <= r_buf_next;
            r_resp       <= r_merged;
            if (r_lane == 2'd3) begin
              s_axi_rdata  <= r_buf_next;
              s_axi_rresp  <= r_merged;
              s_axi_rvalid <= 1'b1;
              r_state      <= RResp;
            end else begin
              r_lane        <= r_lane + 2'd1;
              m_axi_araddr  <= {r_base, r_lane + 2'd1};
              m_axi_arvalid <= 1'b1;
              r_state       <= RAddr;
            end
          end
        end
        RResp: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            r_resp        <= 2'b00;
            s_axi_arready <= 1'b1;
            r_state       <= RIdle;
          end
        end
        default: r_state <= RIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adapter_32_8.sv
// Scoreboard bench for adapter_32_8: directed 32-bit accesses, a byte-wide slave model,
// and monitors that pop hand-computed expectations on every handshake.
module tb_adapter_32_8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] s_axi_awaddr = '0;  logic [2:0] s_axi_awprot = '0;
  logic s_axi_awvalid = 1'b0, s_axi_awready;
  logic [31:0] s_axi_wdata = '0;   logic [3:0] s_axi_wstrb = '0;
  logic s_axi_wvalid = 1'b0, s_axi_wready;
  logic [1:0] s_axi_bresp; logic s_axi_bvalid, s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;  logic [2:0] s_axi_arprot = '0;
  logic s_axi_arvalid = 1'b0, s_axi_arready;
  logic [31:0] s_axi_rdata; logic [1:0] s_axi_rresp; logic s_axi_rvalid, s_axi_rready = 1'b0;
  logic [31:0] m_axi_awaddr; logic [2:0] m_axi_awprot; logic m_axi_awvalid, m_axi_awready = 1'b0;
  logic [7:0] m_axi_wdata; logic m_axi_wstrb, m_axi_wvalid, m_axi_wready = 1'b0;
  logic [1:0] m_axi_bresp = '0; logic m_axi_bvalid = 1'b0, m_axi_bready;
  logic [31:0] m_axi_araddr; logic [2:0] m_axi_arprot; logic m_axi_arvalid, m_axi_arready = 1'b0;
  logic [7:0] m_axi_rdata = '0; logic [1:0] m_axi_rresp = '0;
  logic m_axi_rvalid = 1'b0, m_axi_rready;

  adapter_32_8 #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int checks = 0;
  int errors = 0;
  int lat;

  // Expected traffic, pushed by the stimulus and popped by the monitors.
  logic [34:0] exp_aw[$];   // {prot, addr}
  logic [7:0]  exp_w[$];
  logic [1:0]  exp_b[$];
  logic [34:0] exp_ar[$];   // {prot, addr}
  logic [33:0] exp_r[$];    // {resp, data}

  // Byte slave state.
  logic [31:0] aw_pend[$];
  logic [31:0] ar_pend[$];
  int          w_cnt = 0;
  logic [31:0] wa, ra;
  bit          b_fire = 1'b0, r_fire = 1'b0;
  bit          stall_en = 1'b0, slave_block = 1'b0;
  int          wr_err_lane = -1, rd_err_lane = -1;
  logic [1:0]  wr_err_code = 2'b00, rd_err_code = 2'b00;
  logic [7:0]  rmem [4];

  function automatic bit rnd();
    return stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [7:0] d, input logic [2:0] p);
    exp_aw.push_back({p, a});
    exp_w.push_back(d);
  endtask

  task automatic exp_rd(input logic [31:0] a, input logic [2:0] p);
    exp_ar.push_back({p, a});
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [2:0] p, input int dly);
    repeat (dly) @(negedge clk);
    s_axi_awaddr = a; s_axi_awprot = p; s_axi_awvalid = 1'b1;
    for (int t = 0; !s_axi_awready; t++) begin
      if (t > 300) begin fail("s_aw handshake timeout"); break; end
      @(negedge clk);
    end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    for (int t = 0; !s_axi_wready; t++) begin
      if (t > 300) begin fail("s_w handshake timeout"); break; end
      @(negedge clk);
    end
    @(negedge clk);
    s_axi_wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p, input int aw_gap);
    fork
      send_aw(a, p, aw_gap);
      send_w(d, s);
    join
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] p);
    s_axi_araddr = a; s_axi_arprot = p; s_axi_arvalid = 1'b1;
    for (int t = 0; !s_axi_arready; t++) begin
      if (t > 300) begin fail("s_ar handshake timeout"); break; end
      @(negedge clk);
    end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_aw.size() + exp_w.size() + exp_b.size() + exp_ar.size() + exp_r.size()) != 0) begin
      @(negedge clk);
      t++;
      if (t > 2000) begin
        fail("drain timeout");
        exp_aw.delete(); exp_w.delete(); exp_b.delete(); exp_ar.delete(); exp_r.delete();
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // Byte-wide slave: random readies, one response per accepted byte access.
  initial begin
    forever begin
      @(negedge clk);
      if (b_fire) begin m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; b_fire = 1'b0; end
      if (!m_axi_bvalid && aw_pend.size() != 0 && w_cnt != 0 && rnd()) begin
        wa = aw_pend.pop_front();
        w_cnt--;
        m_axi_bresp  = (wr_err_lane == int'(wa[1:0])) ? wr_err_code : 2'b00;
        m_axi_bvalid = 1'b1;
      end
      if (m_axi_bvalid && m_axi_bready) b_fire = 1'b1;
      if (r_fire) begin m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; r_fire = 1'b0; end
      if (!m_axi_rvalid && ar_pend.size() != 0 && rnd()) begin
        ra = ar_pend.pop_front();
        m_axi_rdata  = (ra[31:2] == 30'h80) ? rmem[ra[1:0]] : 8'h00;
        m_axi_rresp  = (rd_err_lane == int'(ra[1:0])) ? rd_err_code : 2'b00;
        m_axi_rvalid = 1'b1;
      end
      if (m_axi_rvalid && m_axi_rready) r_fire = 1'b1;

      m_axi_awready = slave_block ? 1'b0 : rnd();
      if (m_axi_awvalid && m_axi_awready) begin
        if (exp_aw.size() == 0) fail("unexpected m_aw");
        else check("m_aw prot/addr", 64'({m_axi_awprot, m_axi_awaddr}), 64'(exp_aw.pop_front()));
        aw_pend.push_back(m_axi_awaddr);
      end
      m_axi_wready = slave_block ? 1'b0 : rnd();
      if (m_axi_wvalid && m_axi_wready) begin
        if (exp_w.size() == 0) fail("unexpected m_w");
        else check("m_w strb/data", 64'({m_axi_wstrb, m_axi_wdata}), 64'({1'b1, exp_w.pop_front()}));
        w_cnt++;
      end
      m_axi_arready = slave_block ? 1'b0 : rnd();
      if (m_axi_arvalid && m_axi_arready) begin
        if (exp_ar.size() == 0) fail("unexpected m_ar");
        else check("m_ar prot/addr", 64'({m_axi_arprot, m_axi_araddr}), 64'(exp_ar.pop_front()));
        ar_pend.push_back(m_axi_araddr);
      end
    end
  end

  // Upstream response monitor.
  initial begin
    forever begin
      @(negedge clk);
      s_axi_bready = rnd();
      s_axi_rready = rnd();
      if (s_axi_bvalid && s_axi_bready) begin
        if (exp_b.size() == 0) fail("unexpected s_b");
        else check("s_bresp", 64'(s_axi_bresp), 64'(exp_b.pop_front()));
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_r.size() == 0) fail("unexpected s_r");
        else check("s_r resp/data", 64'({s_axi_rresp, s_axi_rdata}), 64'(exp_r.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rmem[0] = 8'h11; rmem[1] = 8'h22; rmem[2] = 8'h33; rmem[3] = 8'h44;
    repeat (3) @(negedge clk);
    check("reset s ctrl", 64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                               s_axi_arready, s_axi_rvalid, s_axi_rresp}), 64'h0);
    check("reset m ctrl", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                               m_axi_arvalid, m_axi_rready}), 64'h0);
    check("reset s_rdata", 64'(s_axi_rdata), 64'h0);
    check("reset m addr/data", 64'({m_axi_awaddr, m_axi_wdata}), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    check("idle readies", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'h7);

    // Full-word write.
    exp_wr(32'h100, 8'hEF, 3'b000); exp_wr(32'h101, 8'hBE, 3'b000);
    exp_wr(32'h102, 8'hAD, 3'b000); exp_wr(32'h103, 8'hDE, 3'b000);
    exp_b.push_back(2'b00);
    do_write(32'h100, 32'hDEADBEEF, 4'hF, 3'b000, 0);
    wait_idle();

    // Sparse strobe.
    exp_wr(32'h104, 8'h44, 3'b000); exp_wr(32'h106, 8'h22, 3'b000);
    exp_b.push_back(2'b00);
    do_write(32'h104, 32'h11223344, 4'h5, 3'b000, 0);
    wait_idle();

    // Empty strobe: no byte traffic, quick OKAY.
    exp_b.push_back(2'b00);
    do_write(32'h108, 32'hAAAAAAAA, 4'h0, 3'b000, 0);
    lat = 0;
    while (!s_axi_bvalid && lat < 10) begin @(negedge clk); lat++; end
    check("strb0 bvalid latency <= 3", 64'(lat <= 3), 64'h1);
    wait_idle();

    // Read with unaligned address.
    exp_rd(32'h200, 3'b010); exp_rd(32'h201, 3'b010);
    exp_rd(32'h202, 3'b010); exp_rd(32'h203, 3'b010);
    exp_r.push_back({2'b00, 32'h44332211});
    do_read(32'h203, 3'b010);
    wait_idle();

    // Error merge: SLVERR on write lane 2, DECERR on read lane 0.
    wr_err_lane = 2; wr_err_code = 2'b10;
    exp_wr(32'h110, 8'h04, 3'b001); exp_wr(32'h111, 8'h03, 3'b001);
    exp_wr(32'h112, 8'h02, 3'b001); exp_wr(32'h113, 8'h01, 3'b001);
    exp_b.push_back(2'b10);
    do_write(32'h110, 32'h01020304, 4'hF, 3'b001, 0);
    wait_idle();
    rd_err_lane = 0; rd_err_code = 2'b11;
    exp_rd(32'h200, 3'b000); exp_rd(32'h201, 3'b000);
    exp_rd(32'h202, 3'b000); exp_rd(32'h203, 3'b000);
    exp_r.push_back({2'b11, 32'h44332211});
    do_read(32'h200, 3'b000);
    wait_idle();
    wr_err_lane = -1; rd_err_lane = -1;

    // Backpressure everywhere, W ahead of AW, concurrent read.
    stall_en = 1'b1;
    exp_wr(32'h300, 8'h0D, 3'b000); exp_wr(32'h301, 8'hF0, 3'b000);
    exp_wr(32'h302, 8'hFE, 3'b000); exp_wr(32'h303, 8'hCA, 3'b000);
    exp_b.push_back(2'b00);
    exp_rd(32'h200, 3'b100); exp_rd(32'h201, 3'b100);
    exp_rd(32'h202, 3'b100); exp_rd(32'h203, 3'b100);
    exp_r.push_back({2'b00, 32'h44332211});
    fork
      do_write(32'h300, 32'hCAFEF00D, 4'hF, 3'b000, 3);
      do_read(32'h202, 3'b100);
    join
    wait_idle();
    exp_wr(32'h305, 8'h77, 3'b000); exp_wr(32'h307, 8'h55, 3'b000);
    exp_b.push_back(2'b00);
    do_write(32'h304, 32'h55667788, 4'hA, 3'b000, 0);
    wait_idle();
    stall_en = 1'b0;

    // Reset in the middle of a write; the stalled write is abandoned.
    slave_block = 1'b1;
    do_write(32'h400, 32'h12345678, 4'hF, 3'b000, 0);
    repeat (3) @(negedge clk);
    check("stalled m_awvalid", 64'(m_axi_awvalid), 64'h1);
    check("stalled m_awaddr", 64'(m_axi_awaddr), 64'h400);
    rst = 1'b0;
    @(negedge clk);
    check("mid-write reset ctrl", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                                      s_axi_bvalid, s_axi_rvalid, s_axi_awready,
                                      s_axi_wready, s_axi_arready, m_axi_bready,
                                      m_axi_rready}), 64'h0);
    check("mid-write reset addr/data", 64'({m_axi_awaddr, m_axi_wdata}), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    slave_block = 1'b0;
    @(negedge clk);
    exp_wr(32'h500, 8'hF0, 3'b000); exp_wr(32'h501, 8'hDE, 3'b000);
    exp_wr(32'h502, 8'hBC, 3'b000); exp_wr(32'h503, 8'h9A, 3'b000);
    exp_b.push_back(2'b00);
    do_write(32'h500, 32'h9ABCDEF0, 4'hF, 3'b000, 0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
